pipe_ex_mdu: RTL and testbench

Parametrised, iterative RV64M multiply/divide unit for the execute stage of the multi-issue in-order pipeline. It serves `LANES` issue slots with one shared datapath. It resolves the lanes' MDU requests in lane order, holds the pipeline through `mdu_stall` while work is outstanding, and presents all lane results together on a one-cycle `done` beat. It extends the single-cycle ALU path with multi-cycle M-extension support, a configurable number of bits per step, W-variants, special-case fast paths and flush.

---
 rtl/pipe_ex_mdu.sv | 193 +++++++++++++++++++
 tb/tb_pipe_ex_mdu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ex_mdu.sv
// Iterative RV64M multiply/divide unit shared by all issue lanes of the execute stage.
// Lanes are served in index order; results for the whole bundle are released on a one-cycle done beat.
module pipe_ex_mdu #(
  parameter int XLEN           = 64,
  parameter int LANES          = 2,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [LANES-1:0]            req_valid_i,
  input  logic [LANES-1:0][2:0]       req_op_i,
  input  logic [LANES-1:0]            req_word32_i,
  input  logic [LANES-1:0][XLEN-1:0]  req_a_i,
  input  logic [LANES-1:0][XLEN-1:0]  req_b_i,
  output logic                        mdu_stall_o,
  output logic                        done_o,
  output logic [LANES-1:0][XLEN-1:0]  res_o
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(XLEN) + 1;
  localparam int B  = BITS_PER_CYCLE;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  state_t                state_q;
  logic [LANES-1:0]      pend_q;
  logic [LW-1:0]         lane_q;
  logic [CW-1:0]         cnt_q;
  logic [2:0]            op_q;
  logic                  w_q, spec_q, a_neg_q, b_neg_q;
  logic [XLEN-1:0]       spec_res_q;
  logic [2*XLEN-1:0]     acc_q, mcand_q;
  logic [XLEN-1:0]       mplier_q, quo_q, dvsr_q;
  logic [XLEN:0]         rem_q;

  logic [LANES-1:0]      pend_nxt;
  logic [LW-1:0]         sel;
  logic [2:0]            ld_op;
  logic                  ld_w, ld_sa, ld_sb, ld_a_neg, ld_b_neg, ld_ovf, ld_spec, ld_en;
  logic [XLEN-1:0]       ax, bx, ld_mag_a, ld_mag_b, ld_dvd, ld_spec_res;
  logic [CW-1:0]         ld_cnt;

  logic [2*XLEN-1:0]     acc_d, mcand_d, prod;
  logic [XLEN-1:0]       mplier_d, quo_d, quo_s, rem_s, res_val;
  logic [XLEN:0]         rem_d;

  // Operand preparation for the next lane to load: the bundle head from IDLE, else the
  // lowest lane still pending once the current lane retires.
  always_comb begin
    pend_nxt = (state_q == S_IDLE) ? req_valid_i : pend_q;
    if (state_q == S_CALC) pend_nxt[lane_q] = 1'b0;
    sel = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (pend_nxt[i]) sel = LW'(i);
    end
    ld_op    = req_op_i[sel];
    ld_w     = req_word32_i[sel] & ((ld_op == 3'b000) | ld_op[2]);
    ld_sa    = (ld_op == 3'b001) | (ld_op == 3'b010) | (ld_op == 3'b100) | (ld_op == 3'b110);
    ld_sb    = (ld_op == 3'b001) | (ld_op == 3'b100) | (ld_op == 3'b110);
    ax       = ld_w ? (ld_sa ? sext32(req_a_i[sel][31:0]) : XLEN'(req_a_i[sel][31:0])) : req_a_i[sel];
    bx       = ld_w ? (ld_sb ? sext32(req_b_i[sel][31:0]) : XLEN'(req_b_i[sel][31:0])) : req_b_i[sel];
    ld_a_neg = ld_sa & ax[XLEN-1];
    ld_b_neg = ld_sb & bx[XLEN-1];
    ld_mag_a = ld_a_neg ? -ax : ax;
    ld_mag_b = ld_b_neg ? -bx : bx;
    ld_dvd   = ld_w ? sext32(req_a_i[sel][31:0]) : req_a_i[sel];
    ld_ovf   = ld_sa & (ld_w ? ((req_a_i[sel][31:0] == 32'h8000_0000) & (req_b_i[sel][31:0] == 32'hFFFF_FFFF))
                             : ((req_a_i[sel] == MIN_VAL) & (req_b_i[sel] == '1)));
    ld_spec  = ld_op[2] & ((bx == '0) | ld_ovf);
    if (bx == '0) ld_spec_res = ld_op[1] ? ld_dvd : '1;
    else          ld_spec_res = ld_op[1] ? '0 : ld_dvd;
    ld_cnt   = ld_spec ? '0 : (ld_w ? CW'(32/B - 1) : CW'(XLEN/B - 1));
    ld_en    = ~flush_i & (((state_q == S_IDLE) & (|req_valid_i)) |
                           ((state_q == S_CALC) & (cnt_q == '0) & (|pend_nxt)));
  end

  // One iteration: B shift-add multiplier steps and B restoring-divide steps in parallel.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    for (int j = 0; j < B; j++) begin
      if (mplier_d[0]) acc_d = acc_d + mcand_d;
      mcand_d  = mcand_d << 1;
      mplier_d = mplier_d >> 1;
      rem_d    = {rem_d[XLEN-1:0], quo_d[XLEN-1]};
      quo_d    = quo_d << 1;
      if (rem_d >= {1'b0, dvsr_q}) begin
        rem_d    = rem_d - {1'b0, dvsr_q};
        quo_d[0] = 1'b1;
      end
    end
  end

  always_comb begin
    prod  = (a_neg_q ^ b_neg_q) ? -acc_d : acc_d;
    quo_s = (a_neg_q ^ b_neg_q) ? -quo_d : quo_d;
    rem_s = a_neg_q ? -rem_d[XLEN-1:0] : rem_d[XLEN-1:0];
    case (op_q)
      3'b000:                 res_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_val = quo_s;
      default:                res_val = rem_s;
    endcase
    if (w_q)    res_val = sext32(res_val[31:0]);
    if (spec_q) res_val = spec_res_q;
  end

  assign mdu_stall_o = (|req_valid_i) & ~done_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      lane_q     <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      w_q        <= 1'b0;
      spec_q     <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      spec_res_q <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      rem_q      <= '0;
      done_o     <= 1'b0;
      res_o      <= '0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        state_q <= S_IDLE;
        pend_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (|req_valid_i) begin
            pend_q  <= req_valid_i;
            state_q <= S_CALC;
          end
          S_CALC: if (cnt_q == '0) begin
            res_o[lane_q] <= res_val;
            pend_q        <= pend_nxt;
            if (~|pend_nxt) begin
              state_q <= S_DONE;
              done_o  <= 1'b1;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end

      if (ld_en) begin
        lane_q     <= sel;
        op_q       <= ld_op;
        w_q        <= ld_w;
        spec_q     <= ld_spec;
        spec_res_q <= ld_spec_res;
        a_neg_q    <= ld_a_neg;
        b_neg_q    <= ld_b_neg;
        cnt_q      <= ld_cnt;
        acc_q      <= '0;
        mcand_q    <= {{XLEN{1'b0}}, ld_mag_a};
        mplier_q   <= ld_mag_b;
        rem_q      <= '0;
        quo_q      <= ld_w ? (ld_mag_a << (XLEN-32)) : ld_mag_a;
        dvsr_q     <= ld_mag_b;
      end else if (!flush_i && state_q == S_CALC && cnt_q != '0) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        rem_q    <= rem_d;
        quo_q    <= quo_d;
        cnt_q    <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ex_mdu.sv
// Bench for pipe_ex_mdu: two instances (1 and 4 bits per step) checked against an arithmetic
// reference model for results, done latency, stall behaviour, flush and reset abort.
module tb_pipe_ex_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [1:0]           rv  [2];
  logic [1:0][2:0]      rop [2];
  logic [1:0]           rw  [2];
  logic [1:0][63:0]     ra  [2];
  logic [1:0][63:0]     rb  [2];
  logic                 fl  [2];
  logic                 stall [2];
  logic                 done  [2];
  logic [1:0][63:0]     res   [2];
  logic [63:0]          exp_res [2][2];

  int checks = 0;
  int errors = 0;

  pipe_ex_mdu #(.XLEN(64), .LANES(2), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[0]), .req_valid_i(rv[0]), .req_op_i(rop[0]),
    .req_word32_i(rw[0]), .req_a_i(ra[0]), .req_b_i(rb[0]), .mdu_stall_o(stall[0]),
    .done_o(done[0]), .res_o(res[0]));

  pipe_ex_mdu #(.XLEN(64), .LANES(2), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[1]), .req_valid_i(rv[1]), .req_op_i(rop[1]),
    .req_word32_i(rw[1]), .req_a_i(ra[1]), .req_b_i(rb[1]), .mdu_stall_o(stall[1]),
    .done_o(done[1]), .res_o(res[1]));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int bpc(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       p;
    logic [63:0]        r;
    logic [31:0]        r32;
    logic signed [63:0] sa, sb;
    logic signed [31:0] sa32, sb32;
    logic               ovf64, ovf32;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin r = a * b; return w ? sx32(r[31:0]) : r; end
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
      default: begin
        if (w) begin
          case (op)
            3'd4:    r32 = (b[31:0] == 0) ? 32'hFFFF_FFFF : ovf32 ? a[31:0] : 32'(sa32 / sb32);
            3'd5:    r32 = (b[31:0] == 0) ? 32'hFFFF_FFFF : a[31:0] / b[31:0];
            3'd6:    r32 = (b[31:0] == 0) ? a[31:0] : ovf32 ? 32'd0 : 32'(sa32 % sb32);
            default: r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
          endcase
          return sx32(r32);
        end
        case (op)
          3'd4:    r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf64 ? a : 64'(sa / sb);
          3'd5:    r = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
          3'd6:    r = (b == 0) ? a : ovf64 ? 64'd0 : 64'(sa % sb);
          default: r = (b == 0) ? a : a % b;
        endcase
        return r;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b, input int bp);
    logic wh, zero, ovf;
    wh = w && (op == 3'd0 || op[2]);
    if (op[2]) begin
      zero = wh ? (b[31:0] == 0) : (b == 0);
      ovf  = !op[0] && (wh ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                           : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
      if (zero || ovf) return 1;
    end
    return (wh ? 32 : 64) / bp;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic run_bundle(input int d, input string tag, input logic [1:0] v,
                            input logic [1:0][2:0] op, input logic [1:0] w,
                            input logic [1:0][63:0] a, input logic [1:0][63:0] b);
    int lat, k;
    bit seen, stall_ok;
    lat = 1;
    for (int i = 0; i < 2; i++) begin
      if (v[i]) begin
        lat += ref_lat(op[i], w[i], a[i], b[i], bpc(d));
        exp_res[d][i] = ref_res(op[i], w[i], a[i], b[i]);
      end
    end
    @(negedge clk);
    rop[d] = op; rw[d] = w; ra[d] = a; rb[d] = b; rv[d] = v;
    #1;
    check($sformatf("%s_stall_on_req", tag), 64'(stall[d]), 64'd1);
    k = 0; seen = 0; stall_ok = 1;
    while (!seen && k < 300) begin
      @(negedge clk);
      k++;
      if (done[d]) seen = 1;
      else if (!stall[d]) stall_ok = 0;
    end
    check($sformatf("%s_done_cycle", tag), 64'(k), 64'(lat));
    check($sformatf("%s_stall_busy", tag), 64'(stall_ok), 64'd1);
    check($sformatf("%s_stall_at_done", tag), 64'(stall[d]), 64'd0);
    for (int i = 0; i < 2; i++)
      check($sformatf("%s_res%0d", tag, i), res[d][i], exp_res[d][i]);
    rv[d] = 2'b00;
    @(negedge clk);
    check($sformatf("%s_done_pulse", tag), 64'(done[d]), 64'd0);
  endtask

  task automatic flush_test(input int d, input logic [63:0] a, input logic [63:0] b);
    bit seen;
    @(negedge clk);
    rop[d] = {3'd0, 3'd4}; rw[d] = 2'b00; ra[d] = {64'd0, a}; rb[d] = {64'd0, b}; rv[d] = 2'b01;
    repeat (10) @(negedge clk);
    fl[d] = 1'b1;
    @(negedge clk);
    seen = done[d];
    fl[d] = 1'b0; rv[d] = 2'b00;
    repeat (80) begin
      @(negedge clk);
      if (done[d]) seen = 1;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_res0", res[d][0], exp_res[d][0]);
    check("flush_res1", res[d][1], exp_res[d][1]);
    check("flush_stall", 64'(stall[d]), 64'd0);
  endtask

  initial begin
    logic [1:0][2:0]  op;
    logic [1:0]       w, v;
    logic [1:0][63:0] a, b;
    int               d, sel;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = '0; rop[i] = '0; rw[i] = '0; ra[i] = '0; rb[i] = '0; fl[i] = 1'b0;
      exp_res[i][0] = '0; exp_res[i][1] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_res0", res[0][0], 64'd0);
    check("rst_res1", res[0][1], 64'd0);
    check("rst_done", 64'(done[0]), 64'd0);
    check("rst_stall", 64'(stall[0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_bundle(0, "mul_neg", 2'b01, {3'd0, 3'd0}, 2'b00, {64'd0, 64'd7}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFD});
    run_bundle(0, "mulh",    2'b01, {3'd0, 3'd1}, 2'b00, {64'd0, 64'h8000_0000_0000_0000}, {64'd0, 64'd2});
    run_bundle(0, "mulhu",   2'b01, {3'd0, 3'd3}, 2'b00, {64'd0, 64'h8000_0000_0000_0000}, {64'd0, 64'd2});
    run_bundle(0, "divu0",   2'b01, {3'd0, 3'd5}, 2'b00, {64'd0, 64'h1234}, {64'd0, 64'd0});
    run_bundle(0, "remu0",   2'b01, {3'd0, 3'd7}, 2'b00, {64'd0, 64'h1234}, {64'd0, 64'd0});
    run_bundle(0, "div_ovf", 2'b01, {3'd0, 3'd4}, 2'b00, {64'd0, 64'h8000_0000_0000_0000}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    run_bundle(0, "rem_ovf", 2'b01, {3'd0, 3'd6}, 2'b00, {64'd0, 64'h8000_0000_0000_0000}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    run_bundle(0, "divw",    2'b01, {3'd0, 3'd4}, 2'b01, {64'd0, 64'h0000_0000_FFFF_FFF9}, {64'd0, 64'd2});
    run_bundle(0, "remw",    2'b01, {3'd0, 3'd6}, 2'b01, {64'd0, 64'h0000_0000_FFFF_FFF9}, {64'd0, 64'd2});
    run_bundle(0, "two_b1",  2'b11, {3'd5, 3'd0}, 2'b00, {64'd100, 64'd3}, {64'd7, 64'd5});
    run_bundle(1, "two_b4",  2'b11, {3'd5, 3'd0}, 2'b00, {64'd100, 64'd3}, {64'd7, 64'd5});
    run_bundle(0, "lane1",   2'b10, {3'd1, 3'd0}, 2'b00, {64'hFFFF_FFFF_FFFF_FFFF, 64'd9}, {64'd5, 64'd9});

    flush_test(0, 64'd1000, 64'd3);

    for (int it = 0; it < 24; it++) begin
      d = (it % 4 == 3) ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
        op[i] = 3'($urandom_range(0, 7));
        w[i]  = 1'($urandom_range(0, 1));
        a[i]  = {$urandom, $urandom};
        b[i]  = {$urandom, $urandom};
        sel   = $urandom_range(0, 7);
        if (sel == 0) b[i] = 64'd0;
        else if (sel == 1) begin
          op[i][2] = 1'b1; op[i][0] = 1'b0;
          a[i] = w[i] ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b[i] = w[i] ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (sel == 2) b[i] = 64'($urandom_range(1, 9));
      end
      v = 2'($urandom_range(1, 3));
      run_bundle(d, $sformatf("rnd%0d", it), v, op, w, a, b);
    end

    @(negedge clk);
    rop[0] = {3'd4, 3'd0}; rw[0] = 2'b00; ra[0] = {64'd77, 64'd12}; rb[0] = {64'd5, 64'd11}; rv[0] = 2'b11;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_res0", res[0][0], 64'd0);
    check("arst_res1", res[0][1], 64'd0);
    check("arst_done", 64'(done[0]), 64'd0);
    check("arst_dut4_res0", res[1][0], 64'd0);
    rv[0] = 2'b00;
    for (int i = 0; i < 2; i++) begin exp_res[i][0] = '0; exp_res[i][1] = '0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_bundle(0, "post_rst", 2'b01, {3'd0, 3'd4}, 2'b00, {64'd0, 64'hFFFF_FFFF_FFFF_FF9C}, {64'd0, 64'd7});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
